// File: rtl/rv_axi_pkg.sv
// Shared definitions for the rv32 AXI master-side blocks.
//   axarb_state_t : arbiter transaction FSM states (3-bit encoding)
//   AXI_OKAY / AXI_SLVERR : response codes; any code with bit 1 set is an error
//   AXI_AW : default AXI address width
package rv_axi_pkg;

  typedef logic [2:0] u3_t;

  typedef enum u3_t {
    StIdle  = 3'd0,
    StWr    = 3'd1,
    StBwait = 3'd2,
    StRd    = 3'd3,
    StRwait = 3'd4,
    StDone  = 3'd5
  } axarb_state_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  localparam int unsigned AXI_AW = 40;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester arbiter for rv_axi_arbiter.
//   req     : per-requester request vector
//   last    : index of the most recently served requester
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester
// Default build: round-robin, searching last+1 .. last+NREQ modulo NREQ.
// With RV_AXI_ARB_FIXPRIO_EN defined: fixed priority, lowest index wins, last unused.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic found;

`ifdef RV_AXI_ARB_FIXPRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    // Start one past the last winner so every requester gets a turn.
    for (int i = 1; i <= int'(NREQ); i++) begin
      if (!found && req[(int'(last) + i) % int'(NREQ)]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(last) + i) % int'(NREQ));
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/rv_axi_arbiter.sv
// Shares one single-beat 32-bit AXI master port between NREQ simple bus requesters.
// One AXI transaction (len 0) per grant; the granted requester gets a one-cycle ack.
//   aclk, arst_n        : clock, synchronous active-low reset
//   req/wr/adr/dw/be    : requester side, req held until ack
//   ack/dr/err          : completion pulse, read data and error flag (valid with ack)
//   aw*/w*/b*/ar*/r*    : AXI4 master channels, single beat
// Config macro RV_AXI_ARB_FIXPRIO_EN selects fixed priority instead of round-robin.
module rv_axi_arbiter
  import rv_axi_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = AXI_AW
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           wr,
  input  logic [NREQ-1:0][AW-1:0]   adr,
  input  logic [NREQ-1:0][31:0]     dw,
  input  logic [NREQ-1:0][3:0]      be,
  output logic [NREQ-1:0]           ack,
  output logic [31:0]               dr,
  output logic                      err,
  output logic [AW-1:0]             awaddr,
  output logic [7:0]                awlen,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AW-1:0]             araddr,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  input  logic                      rlast,
  output logic                      rready
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  axarb_state_t    state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;

  // Single-beat responses always carry rlast; nothing to check.
  logic unused_rlast;
  assign unused_rlast = rlast;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req     (req),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Channel payloads come from latched copies so they hold while valid is up.
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign awlen  = 8'd0;
  assign arlen  = 8'd0;
  assign wlast  = 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ack       = '0;
    dr        = '0;
    err       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_idx_d = arb_idx;
          addr_d    = adr[arb_idx];
          wdata_d   = dw[arb_idx];
          wstrb_d   = be[arb_idx];
          wr_d      = |(wr & arb_gnt);
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr_d ? StWr : StRd;
        end
      end
      StWr: begin
        // AW and W complete independently, in any order.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = StBwait;
      end
      StBwait: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = (bresp & AXI_SLVERR) != AXI_OKAY;
          state_d = StDone;
        end
      end
      StRd: begin
        arvalid = 1'b1;
        if (arready) state_d = StRwait;
      end
      StRwait: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp & AXI_SLVERR) != AXI_OKAY;
          state_d = StDone;
        end
      end
      StDone: begin
        ack[gnt_idx_q] = 1'b1;
        dr             = wr_q ? 32'd0 : rdata_q;
        err            = err_q;
        last_d         = gnt_idx_q;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      last_q    <= IW'(NREQ - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_rv_axi_arbiter.sv
// Directed self-checking bench for rv_axi_arbiter (NREQ=2, AW=40) with a small AXI slave model.
module tb_rv_axi_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 40;

  logic                    aclk = 1'b0;
  logic                    arst_n;
  logic [NREQ-1:0]         req, wr;
  logic [NREQ-1:0][AW-1:0] adr;
  logic [NREQ-1:0][31:0]   dw;
  logic [NREQ-1:0][3:0]    be;
  logic [NREQ-1:0]         ack;
  logic [31:0]             dr;
  logic                    err;
  logic [AW-1:0]           awaddr, araddr;
  logic [7:0]              awlen, arlen;
  logic                    awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic                    arvalid, arready, rvalid, rlast, rready;
  logic [31:0]             wdata, rdata;
  logic [3:0]              wstrb;
  logic [1:0]              bresp, rresp;

  // Slave knobs
  logic [31:0] rdata_cfg;
  logic [1:0]  rresp_cfg, bresp_cfg;
  logic        r_en;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  rv_axi_arbiter #(
    .NREQ (NREQ),
    .AW   (AW)
  ) dut (
    .aclk    (aclk),
    .arst_n  (arst_n),
    .req     (req),
    .wr      (wr),
    .adr     (adr),
    .dw      (dw),
    .be      (be),
    .ack     (ack),
    .dr      (dr),
    .err     (err),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rlast   (rlast),
    .rready  (rready)
  );

  // Slave: B one cycle after both AW and W handshakes; R one cycle after AR (gated by r_en).
  logic aw_seen, w_seen, b_pend, r_pend;
  assign bvalid = b_pend;
  assign bresp  = bresp_cfg;
  assign rvalid = r_pend && r_en;
  assign rdata  = rdata_cfg;
  assign rresp  = rresp_cfg;
  assign rlast  = 1'b1;

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
      b_pend  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (b_pend && bready) b_pend <= 1'b0;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        b_pend  <= 1'b1;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready) w_seen <= 1'b1;
      end
      if (r_pend && r_en && rready) r_pend <= 1'b0;
      if (arvalid && arready) r_pend <= 1'b1;
    end
  end

  task automatic wait_ack(input int budget, output logic [1:0] got, output int cyc);
    got = '0;
    cyc = 0;
    while (got == 2'b00 && cyc < budget) begin
      @(negedge aclk);
      cyc++;
      got = ack;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(negedge aclk);
    tests++;
    if ({ack, dr, err} !== 35'd0) begin
      fails++; $display("FAIL reset_ack: ack=%b dr=%h err=%b want 0", ack, dr, err);
    end
    tests++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      fails++;
      $display("FAIL reset_valids: %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    tests++;
    if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || wstrb !== '0) begin
      fails++; $display("FAIL reset_payload: aw=%h ar=%h w=%h s=%h want 0", awaddr, araddr,
                        wdata, wstrb);
    end
    tests++;
    if (awlen !== 8'd0 || arlen !== 8'd0 || wlast !== 1'b1) begin
      fails++; $display("FAIL reset_const: awlen=%h arlen=%h wlast=%b want 0/0/1", awlen, arlen,
                        wlast);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge aclk);
    req = 2'b01; wr = 2'b00; adr[0] = 40'h00_1000_0040;
    rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
    @(negedge aclk);  // k+1
    tests++;
    if (arvalid !== 1'b1 || araddr !== 40'h0010000040 || rready !== 1'b0) begin
      fails++; $display("FAIL rd_ar: arvalid=%b araddr=%h rready=%b want 1/0010000040/0",
                        arvalid, araddr, rready);
    end
    @(negedge aclk);  // k+2
    tests++;
    if (arvalid !== 1'b0 || rready !== 1'b1 || ack !== 2'b00) begin
      fails++; $display("FAIL rd_r: arvalid=%b rready=%b ack=%b want 0/1/00", arvalid, rready,
                        ack);
    end
    @(negedge aclk);  // k+3
    tests++;
    if (ack !== 2'b01 || dr !== 32'hDEADBEEF || err !== 1'b0) begin
      fails++; $display("FAIL rd_ack: ack=%b dr=%h err=%b want 01/deadbeef/0", ack, dr, err);
    end
    req = 2'b00;
    @(negedge aclk);
    tests++;
    if (ack !== 2'b00) begin
      fails++; $display("FAIL rd_ack_pulse: ack=%b want 00", ack);
    end
  endtask

  task automatic test_write_delayed();
    @(negedge aclk);
    req = 2'b10; wr = 2'b10; adr[1] = 40'h12_3456_7890; dw[1] = 32'hCAFEF00D; be[1] = 4'b0101;
    awready = 1'b1; wready = 1'b0;
    @(negedge aclk);  // c1
    tests++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 40'h1234567890 ||
        wdata !== 32'hCAFEF00D || wstrb !== 4'b0101) begin
      fails++; $display("FAIL wr_start: awv=%b wv=%b aw=%h w=%h s=%b", awvalid, wvalid, awaddr,
                        wdata, wstrb);
    end
    // Requester changes its inputs; AXI payload must not follow.
    adr[1] = '0; dw[1] = 32'h0; be[1] = 4'hF;
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      tests++;
      if (awvalid !== 1'b0 || wvalid !== 1'b1 || wdata !== 32'hCAFEF00D ||
          wstrb !== 4'b0101 || awaddr !== 40'h1234567890) begin
        fails++; $display("FAIL wr_hold c%0d: awv=%b wv=%b w=%h s=%b aw=%h", c, awvalid, wvalid,
                          wdata, wstrb, awaddr);
      end
    end
    wready = 1'b1;
    @(negedge aclk);  // c5: Bwait
    tests++;
    if (wvalid !== 1'b0 || bready !== 1'b1 || ack !== 2'b00) begin
      fails++; $display("FAIL wr_b: wv=%b bready=%b ack=%b want 0/1/00", wvalid, bready, ack);
    end
    @(negedge aclk);  // c6
    tests++;
    if (ack !== 2'b10 || dr !== 32'd0 || err !== 1'b0) begin
      fails++; $display("FAIL wr_ack: ack=%b dr=%h err=%b want 10/0/0", ack, dr, err);
    end
    req = 2'b00; wr = 2'b00;
    @(negedge aclk);
  endtask

  task automatic test_round_robin();
    logic [1:0] got;
    logic [1:0] exp;
    int cyc;
    @(negedge aclk);
    req = 2'b11; wr = 2'b00; rdata_cfg = 32'h1111_2222;
    for (int n = 0; n < 4; n++) begin
      wait_ack(12, got, cyc);
`ifdef RV_AXI_ARB_FIXPRIO_EN
      exp = 2'b01;
`else
      exp = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL grant_order[%0d]: ack=%b want %b", n, got, exp);
      end
      if (n > 0) begin
        tests++;
        if (cyc !== 4) begin
          fails++; $display("FAIL grant_spacing[%0d]: %0d cycles want 4", n, cyc);
        end
      end
    end
    req = 2'b00;
    @(negedge aclk);
  endtask

  task automatic test_err();
    logic [1:0] got;
    int cyc;
    @(negedge aclk);
    req = 2'b01; wr = 2'b00; rresp_cfg = 2'b10; rdata_cfg = 32'h0BAD0BAD;
    wait_ack(12, got, cyc);
    tests++;
    if (got !== 2'b01 || err !== 1'b1 || dr !== 32'h0BAD0BAD) begin
      fails++; $display("FAIL rd_slverr: ack=%b err=%b dr=%h want 01/1/0bad0bad", got, err, dr);
    end
    req = 2'b00; rresp_cfg = 2'b00;
    @(negedge aclk);
    req = 2'b10; wr = 2'b10; dw[1] = 32'h5; be[1] = 4'h1; bresp_cfg = 2'b11;
    wait_ack(12, got, cyc);
    tests++;
    if (got !== 2'b10 || err !== 1'b1) begin
      fails++; $display("FAIL wr_decerr: ack=%b err=%b want 10/1", got, err);
    end
    req = 2'b00; wr = 2'b00; bresp_cfg = 2'b00;
    @(negedge aclk);
    req = 2'b01; rdata_cfg = 32'h600D600D;
    wait_ack(12, got, cyc);
    tests++;
    if (got !== 2'b01 || err !== 1'b0 || dr !== 32'h600D600D) begin
      fails++; $display("FAIL rd_okay_after_err: ack=%b err=%b dr=%h want 01/0/600d600d", got,
                        err, dr);
    end
    req = 2'b00;
    @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] got;
    int cyc;
    @(negedge aclk);
    r_en = 1'b0; req = 2'b01; wr = 2'b00;
    cyc = 0;
    while (rready !== 1'b1 && cyc < 10) begin
      @(negedge aclk);
      cyc++;
    end
    tests++;
    if (rready !== 1'b1) begin
      fails++; $display("FAIL mid_reach_rwait: rready=%b want 1", rready);
    end
    arst_n = 1'b0;
    @(negedge aclk);
    tests++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0 || ack !== 2'b00) begin
      fails++; $display("FAIL mid_reset: valids=%b ack=%b want 00000/00",
                        {awvalid, wvalid, bready, arvalid, rready}, ack);
    end
    req = 2'b10; r_en = 1'b1; rdata_cfg = 32'h0000_0001;
    @(negedge aclk);
    arst_n = 1'b1;
    wait_ack(12, got, cyc);
    tests++;
    if (got !== 2'b10 || dr !== 32'h0000_0001) begin
      fails++; $display("FAIL mid_after_release: ack=%b dr=%h want 10/00000001", got, dr);
    end
    req = 2'b00;
    @(negedge aclk);
  endtask

  initial begin
    arst_n = 1'b0;
    req = '0; wr = '0; adr = '0; dw = '0; be = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    rdata_cfg = '0; rresp_cfg = 2'b00; bresp_cfg = 2'b00; r_en = 1'b1;
    test_reset();
    test_single_read();
    test_write_delayed();
    test_round_robin();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
